// File: rtl/uart_rx_oversample_if.sv
// Serial receive bundle: line input plus received byte and status pulses.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_oversample_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;

    modport master (output rx, input rx_data, rx_done, rx_busy, frame_err, parity_err);
    modport slave  (input rx, output rx_data, rx_done, rx_busy, frame_err, parity_err);
`else
    modport master (output rx, input rx_data, rx_done, rx_busy, frame_err);
    modport slave  (input rx, output rx_data, rx_done, rx_busy, frame_err);
`endif
endinterface

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN defined).
// Start bit is validated at mid-bit; every later bit is sampled OVS ticks apart.
module uart_rx_oversample #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int OVS      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_rx_oversample_if.slave  bus
);
    localparam int DIV = CLK_FREQ / (BAUD * OVS);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = (OVS > 1) ? $clog2(OVS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state, state_nxt;
    logic            rx_s1, rx_s2;
    logic [TW-1:0]   tick_cnt;
    logic [SW-1:0]   s_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic [7:0]      rx_data;
    logic            rx_done, frame_err;
    logic            tick, mid, clr_cnt, done_nxt, ferr_nxt;

    assign tick = (tick_cnt == TW'(DIV - 1));
    assign mid  = tick && (s_cnt == SW'(OVS - 1));

    always_comb begin
        state_nxt = state;
        clr_cnt   = 1'b0;
        done_nxt  = 1'b0;
        ferr_nxt  = 1'b0;
        case (state)
            IDLE: if (!rx_s2) begin
                state_nxt = START;
                clr_cnt   = 1'b1;
            end
            START: if (tick && s_cnt == SW'(OVS / 2 - 1))
                state_nxt = rx_s2 ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA: if (mid && bit_cnt == 3'd7) state_nxt = PARITY;
            PARITY: if (mid) state_nxt = STOP;
`else
            DATA: if (mid && bit_cnt == 3'd7) state_nxt = STOP;
`endif
            STOP: if (mid) begin
                if (rx_s2) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = WAIT_HIGH;
                    ferr_nxt  = 1'b1;
                end
            end
            WAIT_HIGH: if (rx_s2) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            tick_cnt  <= '0;
            s_cnt     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_s1     <= bus.rx;
            rx_s2     <= rx_s1;
            rx_done   <= done_nxt;
            frame_err <= ferr_nxt;

            if (clr_cnt || tick) tick_cnt <= '0;
            else                 tick_cnt <= tick_cnt + TW'(1);

            // Rebase the sample counter at mid-start so later samples land mid-bit.
            if (clr_cnt) begin
                s_cnt   <= '0;
                bit_cnt <= '0;
            end else if (tick) begin
                if (state == START && s_cnt == SW'(OVS / 2 - 1)) s_cnt <= '0;
                else if (s_cnt == SW'(OVS - 1))                   s_cnt <= '0;
                else                                              s_cnt <= s_cnt + SW'(1);
            end

            if (state == DATA && mid) begin
                shreg   <= {rx_s2, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (done_nxt) rx_data <= shreg;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit, parity_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == PARITY && mid) par_bit <= rx_s2;
            // Even parity: data ones plus parity bit must be even.
            parity_err <= done_nxt && ((^shreg) != par_bit);
        end
    end

    assign bus.parity_err = parity_err;
    assign bus.rx_busy    = (state == START) || (state == DATA) ||
                            (state == PARITY) || (state == STOP);
`else
    assign bus.rx_busy    = (state == START) || (state == DATA) || (state == STOP);
`endif

    assign bus.rx_data   = rx_data;
    assign bus.rx_done   = rx_done;
    assign bus.frame_err = frame_err;
endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: directed frames plus random traffic against a
// queue of expected outcomes (byte/frame error, due cycle) derived from the line timing.
module tb_uart_rx_oversample;
    localparam int CLK_FREQ = 640_000;
    localparam int BAUD     = 10_000;
    localparam int OVS      = 16;
    localparam int DIV      = CLK_FREQ / (BAUD * OVS);
    localparam int BIT_CLKS = DIV * OVS;
`ifdef UART_RX_PARITY_EN
    localparam int SI = 10;
`else
    localparam int SI = 9;
`endif
    // Line edge -> 2 sync flops -> detect, then mid-stop tick, then one registered cycle.
    localparam int DUE_OFS = 3 + (OVS / 2 + SI * OVS) * DIV;

    typedef struct {
        bit         is_done;
        logic [7:0] data;
        bit         perr;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic [7:0] last_data = 8'h00;
    exp_t expq[$];

    uart_rx_oversample_if u_if ();

    uart_rx_oversample #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVS(OVS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        u_if.rx = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop, input bit pbit);
        exp_t e;
        e.is_done = stop;
        e.data    = d;
        e.perr    = stop && ((^d) != pbit);
        e.due     = cyc + DUE_OFS;
        expq.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i]);
            if (i == 3) chk("busy_mid_frame", u_if.rx_busy, 1);
        end
`ifdef UART_RX_PARITY_EN
        drive_bit(pbit);
`endif
        drive_bit(stop);
        chk("busy_after_stop", u_if.rx_busy, 0);
    endtask

    initial begin
        u_if.rx = 1'b1;
        fork
            begin : mon
                exp_t e;
                bit   prev_done;
                prev_done = 1'b0;
                forever begin
                    @(negedge clk);
                    if (!rst) begin
                        chk("done_ferr_excl", u_if.rx_done & u_if.frame_err, 0);
                        if (u_if.rx_done || u_if.frame_err) begin
                            if (expq.size() == 0) begin
                                total++;
                                bad++;
                                $display("FAIL unexpected_pulse: got done=%0b ferr=%0b want none (cycle %0d)",
                                         u_if.rx_done, u_if.frame_err, cyc);
                            end else begin
                                e = expq.pop_front();
                                chk("pulse_kind_done", u_if.rx_done, e.is_done);
                                total++;
                                if (cyc < e.due - DIV || cyc > e.due + DIV) begin
                                    bad++;
                                    $display("FAIL pulse_time: got cycle %0d want %0d", cyc, e.due);
                                end
                                if (e.is_done) last_data = e.data;
`ifdef UART_RX_PARITY_EN
                                chk("parity_err", u_if.parity_err, e.perr);
`endif
                            end
                        end
`ifdef UART_RX_PARITY_EN
                        else chk("parity_err_idle", u_if.parity_err, 0);
`endif
                        chk("rx_data", u_if.rx_data, last_data);
                        if (u_if.rx_done) chk("done_single_cycle", prev_done, 0);
                        prev_done = u_if.rx_done;
                    end else begin
                        prev_done = 1'b0;
                    end
                end
            end
            begin : stim
                wait_clks(5);
                rst = 1'b0;
                wait_clks(2);
                chk("reset_rx_data", u_if.rx_data, 8'h00);
                chk("reset_rx_done", u_if.rx_done, 0);
                chk("reset_rx_busy", u_if.rx_busy, 0);
                chk("reset_frame_err", u_if.frame_err, 0);

                // Plain byte.
                send_frame(8'h55, 1'b1, 1'b0);
                wait_clks(2 * BIT_CLKS);
                chk("byte_55", u_if.rx_data, 8'h55);

                // Short low glitch must be rejected.
                u_if.rx = 1'b0;
                wait_clks(BIT_CLKS * 3 / 10);
                u_if.rx = 1'b1;
                wait_clks(2 * BIT_CLKS);
                chk("glitch_busy_clear", u_if.rx_busy, 0);
                chk("glitch_rx_data", u_if.rx_data, 8'h55);

                // Bad stop bit, then a held-low break.
                send_frame(8'h55, 1'b1, 1'b0);
                send_frame(8'hA3, 1'b0, 1'b0);
                wait_clks(5 * BIT_CLKS);
                u_if.rx = 1'b1;
                wait_clks(2 * BIT_CLKS);
                chk("ferr_keeps_data", u_if.rx_data, 8'h55);

                // Back-to-back frames with no idle.
                send_frame(8'h00, 1'b1, 1'b0);
                send_frame(8'hFF, 1'b1, 1'b0);
                u_if.rx = 1'b1;
                wait_clks(2 * BIT_CLKS);
                chk("b2b_last", u_if.rx_data, 8'hFF);

                // Reset in the middle of data bit 4 of 0x3C.
                drive_bit(1'b0);
                for (int i = 0; i < 4; i++) drive_bit(1'(8'h3C >> i));
                u_if.rx = 1'b1;
                wait_clks(BIT_CLKS / 2);
                rst = 1'b1;
                wait_clks(5);
                rst = 1'b0;
                last_data = 8'h00;
                wait_clks(2 * BIT_CLKS);
                chk("midframe_rst_data", u_if.rx_data, 8'h00);
                chk("midframe_rst_busy", u_if.rx_busy, 0);
                send_frame(8'hC3, 1'b1, 1'b0);
                wait_clks(BIT_CLKS);
                chk("after_rst_byte", u_if.rx_data, 8'hC3);

`ifdef UART_RX_PARITY_EN
                send_frame(8'h07, 1'b1, 1'b0);
                wait_clks(BIT_CLKS);
                send_frame(8'h07, 1'b1, 1'b1);
                wait_clks(BIT_CLKS);
                chk("parity_byte", u_if.rx_data, 8'h07);
`endif

                // Random traffic.
                for (int n = 0; n < 25; n++) begin
                    logic [7:0] d;
                    bit         stop, pbit;
                    int         gap;
                    d    = 8'($urandom);
                    stop = ($urandom_range(0, 9) != 0);
                    pbit = 1'($urandom);
                    send_frame(d, stop, pbit);
                    u_if.rx = 1'b1;
                    gap = stop ? $urandom_range(0, 2 * BIT_CLKS) : BIT_CLKS + $urandom_range(0, BIT_CLKS);
                    if (gap > 0) wait_clks(gap);
                end
                wait_clks(2 * BIT_CLKS);
                chk("expect_queue_empty", expq.size(), 0);
            end
        join_any
        disable fork;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_oversample.md
UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate.
REQ-003 Parameter OVS, default 16, samples per bit; tick divisor DIV = CLK_FREQ/(BAUD*OVS), integer-truncated (651 at defaults).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rx  input  1  asynchronous serial line, idle high.
REQ-007 rx_data  output  8  last correctly framed byte, LSB received first.
REQ-008 rx_done  output  1  one-clock pulse; rx_data valid in the same cycle. Suitable as a direct FIFO wr strobe.
REQ-009 rx_busy  output  1  high from the validated start bit until the frame ends.
REQ-010 frame_err  output  1  one-clock pulse when the stop bit samples low.
REQ-011 parity_err  output  1  one-clock pulse on even-parity mismatch; present only with UART_RX_PARITY_EN.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 Tick generator SHALL pulse once every DIV clocks; its counter SHALL clear on start-edge detection so ticks align to the frame.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
REQ-015 IDLE: synchronized rx low -> START, clear tick and sample counters.
REQ-016 START: at tick OVS/2-1 (7), rx still low -> DATA; rx high -> IDLE (glitch reject, no output pulse).
REQ-017 DATA: sample rx every OVS ticks from the mid-start point, i.e. mid-bit; shift into bit 7 (LSB first); after 8 bits -> PARITY or STOP.
REQ-018 STOP: sample at mid-bit; high -> rx_data loads shift register, rx_done pulses, -> IDLE; low -> frame_err pulses, rx_data unchanged, -> WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until synchronized rx high (break condition), then -> IDLE.
REQ-020 Latency: rx_done asserts exactly one clock after the mid-stop-bit sampling tick.
REQ-021 A start bit immediately following the stop bit (no idle time) SHALL be received without loss.
REQ-022 rx_done and frame_err SHALL never assert in the same cycle.

Reset
REQ-023 On rst: FSM=IDLE, rx_data=8'h00, rx_done=0, rx_busy=0, frame_err=0, parity_err=0, synchronizer flops=1, all counters=0.
REQ-024 Reset mid-frame SHALL abandon the frame with no output pulse; reception restarts on the next falling edge after rst deasserts.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: PARITY state samples a ninth bit at mid-bit; mismatch with even parity of the data pulses parity_err together with rx_done, and the byte is still delivered; STOP follows.
REQ-026 UART_RX_PARITY_EN undefined: no PARITY state, no parity_err port; frame is 8N1.

Verification (defaults: 10416 clocks/bit)
REQ-027 Send 8N1 byte 0x55 -> rx_data=0x55, single-cycle rx_done, frame_err=0, rx_busy low afterwards.
REQ-028 Drive rx low for 3000 clocks, then high -> no rx_done, no frame_err, rx_busy returns to 0 and FSM returns to IDLE.
REQ-029 Send 0x55, then 0xA3 with stop bit=0 -> frame_err pulse, no rx_done, rx_data stays 0x55; hold rx low 5 bit-times -> no further pulses until rx high.
REQ-030 Send 0x00 and 0xFF back-to-back with no idle -> two rx_done pulses, rx_data 0x00 then 0xFF.
REQ-031 Assert rst during data bit 4 of 0x3C, then send 0xC3 -> no pulse for 0x3C, rx_data=0xC3 with rx_done.
REQ-032 With UART_RX_PARITY_EN: send 0x07 with parity bit 0 -> rx_done and parity_err together, rx_data=0x07; with parity bit 1 -> parity_err=0.
